// File: rtl/nibble_mem_bridge.sv
// Fabric-side endpoint of the nibble-serial memory link: assembles 4-bit request
// beats into word accesses on a single-port memory and serializes read data back.
module nibble_mem_bridge #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [3:0]           req_data_i,
  input  logic                 req_strb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [3:0]           rsp_data_o,
  output logic                 rsp_last_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i
);

  if (DataWidth != 32) begin : g_width_check
    $error("nibble_mem_bridge: DataWidth must be 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_MEM,
    RD_MEM,
    RD_WAIT,
    RSP_SEND,
    RSP_COMMIT
  } state_t;

  state_t                 state;
  logic [2:0]             cnt;
  logic [31:0]            data;
  logic [7:0]             strb;
  logic [AddrWidth-1:0]   addr;
  logic [3:0]             be_pairs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 3'd0;
      data  <= 32'd0;
      strb  <= 8'd0;
      addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr <= req_addr_i;
            if (req_write_i) begin
              // First nibble clears leftovers from the previous access.
              data  <= {28'd0, req_data_i};
              strb  <= {7'd0, req_strb_i};
              cnt   <= 3'd1;
              state <= WR_COLLECT;
            end else begin
              state <= RD_MEM;
            end
          end
        end
        WR_COLLECT: begin
          if (req_valid_i) begin
            data[{cnt, 2'b00} +: 4] <= req_data_i;
            strb[cnt]               <= req_strb_i;
            cnt                     <= cnt + 3'd1;
            if (cnt == 3'd7) state <= WR_MEM;
          end
        end
        WR_MEM: begin
          if (mem_gnt_i) state <= IDLE;
        end
        RD_MEM: begin
          if (mem_gnt_i) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            data  <= mem_rdata_i;
            cnt   <= 3'd0;
            state <= RSP_SEND;
          end
        end
        RSP_SEND: begin
          if (rsp_ready_i) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) state <= RSP_COMMIT;
          end
        end
        RSP_COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A byte is written only when both of its nibble strobes were set.
  always_comb begin
    be_pairs = 4'd0;
    for (int i = 0; i < 4; i++) begin
      be_pairs[i] = strb[2*i] & strb[2*i+1];
    end
  end

  always_comb begin
    req_ready_o = req_valid_i & ~rst_i & ((state == IDLE) || (state == WR_COLLECT));
    mem_req_o   = (state == WR_MEM) || (state == RD_MEM);
    mem_we_o    = (state == WR_MEM);
    mem_addr_o  = mem_req_o ? addr : '0;
    mem_wdata_o = (state == WR_MEM) ? data : 32'd0;
    mem_be_o    = 4'd0;
    if (state == WR_MEM) mem_be_o = be_pairs;
    else if (state == RD_MEM) mem_be_o = 4'hF;
    rsp_valid_o = (state == RSP_SEND) || (state == RSP_COMMIT);
    // MSB nibble first: index 7-cnt equals ~cnt for a 3-bit counter.
    rsp_data_o  = (state == RSP_SEND) ? data[{~cnt, 2'b00} +: 4] : 4'd0;
    rsp_last_o  = (state == RSP_SEND) && (cnt == 3'd7);
  end

endmodule
